// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: base opcodes, immediate formats and the immediate builder.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_t;

    // B and J immediates are scrambled in the encoding; reassemble with bit 0 forced low.
    function automatic logic [31:0] gen_imm(input imm_fmt_t fmt, input logic [31:0] instr);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Fetch-side and execute-side handshakes of the decode/issue stage.
interface decode_issue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rs1_val;
    logic [XLEN-1:0] out_rs2_val;
    logic [XLEN-1:0] out_imm;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [4:0]      out_rd;
    logic            out_writes_rd;
    logic            out_illegal;

    // The surrounding pipeline (fetch + execute) is the master of both channels.
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
               out_opcode, out_funct3, out_funct7, out_rd, out_writes_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
               out_opcode, out_funct3, out_funct7, out_rd, out_writes_rd, out_illegal
    );
endinterface

// File: rtl/decode_issue_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set on issue, cleared on writeback or kill.
module decode_issue_scoreboard #(
    parameter int NREG = 32,
    parameter int IW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_en,
    input  logic [IW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [IW-1:0] clr_idx,
    input  logic          kill_en,
    input  logic [IW-1:0] kill_idx,
    input  logic [IW-1:0] rs1_idx,
    input  logic [IW-1:0] rs2_idx,
    input  logic [IW-1:0] rd_idx,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          rd_busy
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    // Clears first, then the set, so a new issue outranks a same-cycle retire of that register.
    always_comb begin
        busy_next = busy;
        if (clr_en)  busy_next[clr_idx]  = 1'b0;
        if (kill_en) busy_next[kill_idx] = 1'b0;
        if (set_en)  busy_next[set_idx]  = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy <= '0;
        else        busy <= busy_next;
    end

    assign rs1_busy = busy[rs1_idx];
    assign rs2_busy = busy[rs2_idx];
    assign rd_busy  = busy[rd_idx];

endmodule

// File: rtl/decode_issue.sv
// RV32I decode/issue stage: decodes one instruction per cycle, stalls on RAW/WAW, registers the packet.
module decode_issue
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    decode_issue_if.slave   io,
    output logic [4:0]      rf_read_reg1,
    output logic [4:0]      rf_read_reg2,
    input  logic [XLEN-1:0] rf_read_data1,
    input  logic [XLEN-1:0] rf_read_data2,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush
);

    logic [6:0]      opcode;
    logic [4:0]      rd;
    imm_fmt_t        fmt;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            writes_rd_raw;
    logic            writes_rd;
    logic            illegal;
    logic [XLEN-1:0] imm;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rd_busy;
    logic            hazard;
    logic            accept;

    assign opcode       = io.in_instr[6:0];
    assign rd           = io.in_instr[11:7];
    assign rf_read_reg1 = io.in_instr[19:15];
    assign rf_read_reg2 = io.in_instr[24:20];

    always_comb begin
        fmt           = IMM_NONE;
        uses_rs1      = 1'b0;
        uses_rs2      = 1'b0;
        writes_rd_raw = 1'b0;
        illegal       = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                fmt           = IMM_U;
                writes_rd_raw = 1'b1;
            end
            OPC_JAL: begin
                fmt           = IMM_J;
                writes_rd_raw = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                fmt           = IMM_I;
                uses_rs1      = 1'b1;
                writes_rd_raw = 1'b1;
            end
            OPC_BRANCH: begin
                fmt      = IMM_B;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_STORE: begin
                fmt      = IMM_S;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_OP: begin
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
                writes_rd_raw = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // x0 is never tracked, so a write to it neither stalls nor occupies the scoreboard.
    assign writes_rd = writes_rd_raw & (rd != 5'd0);
    assign imm       = XLEN'($signed(gen_imm(fmt, io.in_instr)));

    decode_issue_scoreboard #(.NREG(NREG)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (accept & writes_rd),
        .set_idx  (rd),
        .clr_en   (wb_valid),
        .clr_idx  (wb_rd),
        .kill_en  (flush & io.out_valid & io.out_writes_rd),
        .kill_idx (io.out_rd),
        .rs1_idx  (rf_read_reg1),
        .rs2_idx  (rf_read_reg2),
        .rd_idx   (rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );

    assign hazard      = (uses_rs1 & rs1_busy) | (uses_rs2 & rs2_busy) | (writes_rd & rd_busy);
    assign io.in_ready = (!io.out_valid | io.out_ready) & !hazard & !flush;
    assign accept      = io.in_valid & io.in_ready;

    // Flush never coincides with an accept because in_ready is held low during it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io.out_valid     <= 1'b0;
            io.out_pc        <= '0;
            io.out_rs1_val   <= '0;
            io.out_rs2_val   <= '0;
            io.out_imm       <= '0;
            io.out_opcode    <= '0;
            io.out_funct3    <= '0;
            io.out_funct7    <= '0;
            io.out_rd        <= '0;
            io.out_writes_rd <= 1'b0;
            io.out_illegal   <= 1'b0;
        end else if (accept) begin
            io.out_valid     <= 1'b1;
            io.out_pc        <= io.in_pc;
            io.out_rs1_val   <= rf_read_data1;
            io.out_rs2_val   <= rf_read_data2;
            io.out_imm       <= imm;
            io.out_opcode    <= opcode;
            io.out_funct3    <= io.in_instr[14:12];
            io.out_funct7    <= io.in_instr[31:25];
            io.out_rd        <= rd;
            io.out_writes_rd <= writes_rd;
            io.out_illegal   <= illegal;
        end else if (flush || io.out_ready) begin
            io.out_valid <= 1'b0;
        end
    end

endmodule
